uart_tx_queue: RTL and testbench
================================

UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 Parameter DEPTH_LOG2, default 4; queue depth is 2**DEPTH_LOG2 bytes.
REQ-002 Parameter ACK_TIMEOUT, default 15; maximum cycles to wait for tx_busy rise after tx_start before retrying.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rstn  in  1  reset, asynchronous and active-low.
REQ-005 push  in  1  core request to enqueue wr_data this cycle (OUT instruction side).
REQ-006 wr_data  in  8  byte to enqueue.
REQ-007 full  out  1  high when count == 2**DEPTH_LOG2.
REQ-008 empty  out  1  high when count == 0.
REQ-009 count  out  DEPTH_LOG2+1  number of bytes held, excluding any byte already handed to the transmitter.
REQ-010 overflow  out  1  sticky; set when a push is dropped.
REQ-011 tx_data  out  8  byte presented to uart_tx data input.
REQ-012 tx_start  out  1  one-cycle start pulse to uart_tx.
REQ-013 tx_busy  in  1  busy flag from uart_tx.
REQ-014 idle  out  1  high when state is IDLE and empty is high (all output drained).

Function
REQ-015 Storage SHALL be a circular buffer with wr_ptr, rd_ptr of DEPTH_LOG2 bits, wrapping modulo 2**DEPTH_LOG2.
REQ-016 push with full low SHALL write wr_data at wr_ptr, increment wr_ptr and count on the same edge.
REQ-017 push with full high SHALL be dropped, leave pointers/count unchanged and set overflow; full is evaluated on the registered count, so a same-cycle dequeue does not admit the push.
REQ-018 State machine states: IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-019 IDLE -> START when empty low and tx_busy low; on that edge tx_data is loaded from buffer[rd_ptr], rd_ptr increments, count decrements.
REQ-020 Simultaneous push (accepted) and dequeue in one cycle SHALL leave count unchanged and both pointers advanced.
REQ-021 START: tx_start high for exactly this one cycle; next state WAIT_ACK unconditionally; tx_data held stable.
REQ-022 WAIT_ACK: -> WAIT_DONE when tx_busy high; if tx_busy stays low for ACK_TIMEOUT cycles -> START (re-pulse, same tx_data, no dequeue).
REQ-023 WAIT_DONE: -> IDLE when tx_busy low; tx_data held stable until leaving WAIT_DONE.
REQ-024 Minimum spacing between consecutive tx_start pulses is 3 cycles plus the busy period; back-to-back bytes SHALL leave no further idle cycles beyond IDLE re-evaluation (1 cycle).
REQ-025 tx_start SHALL be low in all states other than START.
REQ-026 Bytes SHALL be transmitted in push order with no loss or duplication (except the timeout re-pulse, which resends the same byte only if the transmitter never acknowledged).
REQ-027 full, empty, idle are combinational from registered count/state.

Reset
REQ-028 On rstn low (asynchronous): state IDLE, wr_ptr=0, rd_ptr=0, count=0, overflow=0, tx_start=0, tx_data=8'h00; hence empty=1, full=0, idle=1.
REQ-029 Reset asserted mid-transmission SHALL discard queued and in-flight bytes; tx_start SHALL drop immediately, without waiting for a clock edge.
REQ-030 Buffer contents need not be reset.

Verification
REQ-031 Reset then push 8'h41, 8'h42, 8'h43 on consecutive cycles, uart_tx model busy 10 cycles per byte -> tx_start pulses carry 41, 42, 43 in order; empty and idle return to 1.
REQ-032 DEPTH_LOG2=4, tx_busy held high, push 17 bytes -> count=16, full=1, 17th byte dropped, overflow=1; release tx_busy -> exactly 16 bytes sent, overflow stays 1.
REQ-033 With count=16 and a dequeue in the same cycle as push -> push dropped, count=15 afterwards.
REQ-034 With count=5, push in the IDLE->START cycle -> count stays 5; push 20 bytes total while draining, wr_ptr wraps past 15 -> output order intact.
REQ-035 tx_busy never rises after tx_start -> re-pulse after ACK_TIMEOUT=15 cycles with the same tx_data, no dequeue.
REQ-036 Assert rstn low during WAIT_DONE with 3 bytes queued -> outputs return to reset values asynchronously; after release no tx_start until a new push.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Byte queue feeding a uart_tx: circular buffer plus a handshake FSM that pulses
// tx_start, waits for the transmitter's busy acknowledge and re-pulses on timeout.
module uart_tx_queue #(
   parameter int DEPTH_LOG2  = 4,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  push,
   input  logic [7:0]            wr_data,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic [7:0]            tx_data,
   output logic                  tx_start,
   input  logic                  tx_busy,
   output logic                  idle
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;
   localparam int TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_ACK  = 2'd2,
      ST_WAIT_DONE = 2'd3
   } state_t;

   state_t                  state_r;
   state_t                  next_state_s;
   logic [7:0]              mem_r [DEPTH];
   logic [DEPTH_LOG2-1:0]   wr_ptr_r;
   logic [DEPTH_LOG2-1:0]   rd_ptr_r;
   logic [CNT_W-1:0]        count_r;
   logic                    overflow_r;
   logic [7:0]              tx_data_r;
   logic                    tx_start_r;
   logic [TMR_W-1:0]        timer_r;
   logic                    full_s;
   logic                    empty_s;
   logic                    push_ok_s;
   logic                    deq_s;

   // Flags decode the registered count only, so a same-cycle dequeue never admits a push.
   assign full_s    = (count_r == FULL_CNT);
   assign empty_s   = (count_r == {CNT_W{1'b0}});
   assign push_ok_s = push & ~full_s;

   assign full     = full_s;
   assign empty    = empty_s;
   assign idle     = (state_r == ST_IDLE) & empty_s;
   assign count    = count_r;
   assign overflow = overflow_r;
   assign tx_data  = tx_data_r;
   assign tx_start = tx_start_r;

   // Next-state decode; deq_s marks the IDLE->START hand-off that pops a byte.
   always_comb begin
      next_state_s = state_r;
      deq_s        = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (!empty_s && !tx_busy) begin
               next_state_s = ST_START;
               deq_s        = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            next_state_s = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (tx_busy) begin
               next_state_s = ST_WAIT_DONE;
            end else if (timer_r == TMR_LAST) begin
               next_state_s = ST_START;
            end else begin
               next_state_s = ST_WAIT_ACK;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) begin
               next_state_s = ST_IDLE;
            end else begin
               next_state_s = ST_WAIT_DONE;
            end
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State register, acknowledge timer and registered transmitter outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= ST_IDLE;
         timer_r    <= {TMR_W{1'b0}};
         tx_start_r <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         state_r    <= next_state_s;
         tx_start_r <= (next_state_s == ST_START);
         if ((state_r == ST_WAIT_ACK) && (next_state_s == ST_WAIT_ACK)) begin
            timer_r <= timer_r + TMR_W'(1);
         end else begin
            timer_r <= {TMR_W{1'b0}};
         end
         if (deq_s) begin
            tx_data_r <= mem_r[rd_ptr_r];
         end else begin
            tx_data_r <= tx_data_r;
         end
      end
   end

   // Queue pointers, occupancy and sticky overflow.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
         rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
         count_r    <= {CNT_W{1'b0}};
         overflow_r <= 1'b0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= wr_ptr_r + DEPTH_LOG2'(1);
         end
         if (deq_s) begin
            rd_ptr_r <= rd_ptr_r + DEPTH_LOG2'(1);
         end
         case ({push_ok_s, deq_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
         if (push && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue: behavioural uart_tx responder plus a
// push-order scoreboard and directed/randomized scenarios.
module tb_uart_tx_queue;

   localparam int ACK_TIMEOUT = 15;

   logic       clk;
   logic       rstn;
   logic       push;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy;
   logic       idle;

   logic       hold_busy;
   logic       busy_m;
   assign tx_busy = hold_busy | busy_m;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] exp_q [$];
   bit         ack_en;
   bit         gap_chk;
   bit         rand_len;
   bit         rand_delay;
   int         fixed_len;
   int         pulses = 0;
   bit         resend;

   uart_tx_queue #(.DEPTH_LOG2(4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .push     (push),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .idle     (idle)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_push(input logic [7:0] b, input bit acc);
      push    = 1'b1;
      wr_data = b;
      if (acc) exp_q.push_back(b);
      @(negedge clk);
      push = 1'b0;
   endtask

   task automatic wait_drain(input string tag, input int n_exp, input int budget);
      for (int i = 0; i < budget; i++) begin
         if (pulses == n_exp && idle && !tx_busy && exp_q.size() == 0 && !resend) break;
         @(negedge clk);
      end
      chk({tag, "_pulses"}, pulses, n_exp);
      chk({tag, "_idle"}, {31'd0, idle}, 32'd1);
      chk({tag, "_left"}, exp_q.size(), 32'd0);
   endtask

   // Behavioural uart_tx plus scoreboard: every tx_start must carry the next pushed byte,
   // or repeat the previous one when that start was never acknowledged.
   initial begin : txm
      int         cyc;
      int         last_cyc;
      int         delay_left;
      int         busy_left;
      int         cur_len;
      int         last_len;
      bit         have_prev;
      bit         prev_start;
      logic [7:0] last_b;
      logic [7:0] exp_b;
      cyc = 0; last_cyc = 0; delay_left = 0; busy_left = 0; cur_len = 0; last_len = 0;
      have_prev = 1'b0; prev_start = 1'b0; last_b = 8'h00; exp_b = 8'h00;
      busy_m = 1'b0; resend = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rstn) begin
            busy_left = 0; delay_left = 0; busy_m = 1'b0; resend = 1'b0;
            have_prev = 1'b0; prev_start = 1'b0;
            exp_q.delete();
         end else begin
            if (hold_busy) have_prev = 1'b0;
            if (delay_left > 0) begin
               delay_left--;
               if (delay_left == 0) busy_left = cur_len;
            end
            if (tx_start) begin
               pulses++;
               chk("start_one_cycle", {31'd0, prev_start}, 32'd0);
               chk("pulse_expected", {31'd0, (resend || exp_q.size() > 0)}, 32'd1);
               if (resend) begin
                  exp_b = last_b;
                  chk("timeout_gap", cyc - last_cyc, ACK_TIMEOUT + 1);
               end else begin
                  if (gap_chk && have_prev) chk("b2b_gap", cyc - last_cyc, 3 + last_len);
                  if (exp_q.size() > 0) exp_b = exp_q.pop_front();
                  else exp_b = 8'h00;
               end
               chk("tx_data_order", {24'd0, tx_data}, {24'd0, exp_b});
               resend = !ack_en;
               if (ack_en) begin
                  delay_left = rand_delay ? int'($urandom_range(3, 1)) : 1;
                  cur_len    = rand_len ? int'($urandom_range(5, 2)) : fixed_len;
               end
               last_cyc  = cyc;
               last_b    = exp_b;
               last_len  = cur_len;
               have_prev = 1'b1;
            end
            prev_start = tx_start;
            busy_m = (busy_left > 0);
            if (busy_left > 0) busy_left--;
         end
      end
   end

   initial begin : main
      int base;
      rstn = 1'b0; push = 1'b0; wr_data = 8'h00; hold_busy = 1'b0;
      ack_en = 1'b1; gap_chk = 1'b0; rand_len = 1'b0; rand_delay = 1'b0; fixed_len = 10;
      repeat (3) @(negedge clk);
      chk("rst_empty",    {31'd0, empty},    32'd1);
      chk("rst_full",     {31'd0, full},     32'd0);
      chk("rst_idle",     {31'd0, idle},     32'd1);
      chk("rst_count",    {27'd0, count},    32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
      chk("rst_tx_data",  {24'd0, tx_data},  32'd0);
      rstn = 1'b1;
      @(negedge clk);

      // three bytes, 10-cycle busy
      gap_chk = 1'b1;
      base = pulses;
      do_push(8'h41, 1'b1);
      do_push(8'h42, 1'b1);
      do_push(8'h43, 1'b1);
      wait_drain("t1", base + 3, 200);
      chk("t1_empty", {31'd0, empty}, 32'd1);

      // fill to 16 while held busy, 17th dropped
      rand_len  = 1'b1;
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) do_push(8'($urandom), 1'b1);
      do_push(8'($urandom), 1'b0);
      chk("t2_count",    {27'd0, count},    32'd16);
      chk("t2_full",     {31'd0, full},     32'd1);
      chk("t2_overflow", {31'd0, overflow}, 32'd1);
      chk("t2_empty",    {31'd0, empty},    32'd0);
      base = pulses;
      hold_busy = 1'b0;
      wait_drain("t2", base + 16, 400);
      chk("t2_overflow_sticky", {31'd0, overflow}, 32'd1);

      // full queue, push in the dequeue cycle is still dropped
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      chk("t3_rst_overflow", {31'd0, overflow}, 32'd0);
      rstn = 1'b1;
      @(negedge clk);
      hold_busy = 1'b1;
      for (int i = 0; i < 16; i++) do_push(8'($urandom), 1'b1);
      chk("t3_full", {31'd0, full}, 32'd1);
      base = pulses;
      hold_busy = 1'b0;
      do_push(8'($urandom), 1'b0);
      chk("t3_count",    {27'd0, count},    32'd15);
      chk("t3_overflow", {31'd0, overflow}, 32'd1);
      chk("t3_not_full", {31'd0, full},     32'd0);
      wait_drain("t3", base + 16, 400);

      // count 5, push on dequeue edge, then 14 more random pushes with wrap
      hold_busy = 1'b1;
      for (int i = 0; i < 5; i++) do_push(8'($urandom), 1'b1);
      chk("t4_count5", {27'd0, count}, 32'd5);
      gap_chk = 1'b0;
      rand_delay = 1'b1;
      base = pulses;
      hold_busy = 1'b0;
      do_push(8'($urandom), 1'b1);
      chk("t4_push_on_deq", {27'd0, count}, 32'd5);
      for (int i = 0; i < 14; i++) begin
         repeat ($urandom_range(6, 2)) @(negedge clk);
         do_push(8'($urandom), 1'b1);
      end
      wait_drain("t4", base + 20, 600);

      // transmitter never acknowledges: re-pulse, no dequeue
      rand_delay = 1'b0;
      ack_en = 1'b0;
      base = pulses;
      do_push(8'($urandom), 1'b1);
      do_push(8'($urandom), 1'b1);
      for (int i = 0; i < 100 && pulses < base + 2; i++) @(negedge clk);
      chk("t5_repulse",    pulses,         base + 2);
      chk("t5_no_dequeue", {27'd0, count}, 32'd1);
      @(posedge clk);
      ack_en = 1'b1;
      @(negedge clk);
      wait_drain("t5", base + 4, 200);

      // async reset during WAIT_DONE with three bytes queued
      rand_len = 1'b0;
      fixed_len = 20;
      for (int i = 0; i < 4; i++) do_push(8'($urandom), 1'b1);
      for (int i = 0; i < 50 && !(tx_busy && count == 5'd3); i++) @(negedge clk);
      chk("t6_busy_q3", {31'd0, (tx_busy && count == 5'd3)}, 32'd1);
      @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      chk("t6_async_count",    {27'd0, count},    32'd0);
      chk("t6_async_empty",    {31'd0, empty},    32'd1);
      chk("t6_async_idle",     {31'd0, idle},     32'd1);
      chk("t6_async_tx_data",  {24'd0, tx_data},  32'd0);
      chk("t6_async_tx_start", {31'd0, tx_start}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      base = pulses;
      repeat (30) @(negedge clk);
      chk("t6_no_start", pulses, base);
      chk("t6_idle", {31'd0, idle}, 32'd1);

      // async reset while tx_start is high
      fixed_len = 4;
      do_push(8'($urandom), 1'b1);
      for (int i = 0; i < 20; i++) begin
         if (tx_start) break;
         @(negedge clk);
      end
      chk("t6b_start_seen", {31'd0, tx_start}, 32'd1);
      #1 rstn = 1'b0;
      #1;
      chk("t6b_start_drop", {31'd0, tx_start}, 32'd0);
      chk("t6b_tx_data",    {24'd0, tx_data},  32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk("t6b_idle",  {31'd0, idle},  32'd1);
      chk("t6b_empty", {31'd0, empty}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
